// File: rtl/i2s_frame_scheduler_pkg.sv
// Shared definitions for the I2S frame scheduler: state encodings, underrun
// modes and the saturating counter helper.
package i2s_frame_scheduler_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam int UNDERRUN_ZERO   = 0;
  localparam int UNDERRUN_REPEAT = 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/i2s_frame_scheduler_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output. A pop and a
// push in the same cycle are both accepted, even when the FIFO is full.
module i2s_frame_scheduler_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_pop_ok  = pop & (r_count != '0);
  assign w_push_ok = push & ((r_count != CNT_MAX) | w_pop_ok);
  assign pop_data  = r_mem[r_rd_ptr];
  assign level     = r_count;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2s_frame_scheduler.sv
// Frame-level sequencer for the I2S master: TX prefill/holds, RX frame capture,
// IDLE/PRIME/RUN sequencing and saturating underrun/overrun counters.
module i2s_frame_scheduler
  import i2s_frame_scheduler_pkg::*;
#(
  parameter int DSZ           = 16,
  parameter int DEPTH         = 8,
  parameter int PREFILL       = 2,
  parameter int UNDERRUN_MODE = 0
) (
  input  logic                   i2s_bclk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   cnt_clear,
  input  logic                   i2s_lrclk,
  input  logic [DSZ-1:0]         i2s_left_rx,
  input  logic [DSZ-1:0]         i2s_right_rx,
  output logic [DSZ-1:0]         i2s_left_tx,
  output logic [DSZ-1:0]         i2s_right_tx,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [DSZ-1:0]         tx_left,
  input  logic [DSZ-1:0]         tx_right,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [DSZ-1:0]         rx_left,
  output logic [DSZ-1:0]         rx_right,
  output logic                   frame_tick,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [7:0]             underrun_cnt,
  output logic [7:0]             overrun_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_FULL    = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PREFILL = LW'(PREFILL);

  logic           r_lrclk_q;
  logic [1:0]     r_state;
  logic [DSZ-1:0] r_left_tx;
  logic [DSZ-1:0] r_right_tx;
  logic [7:0]     r_underrun_cnt;
  logic [7:0]     r_overrun_cnt;

  logic             w_tick;
  logic [LW-1:0]    w_tx_level;
  logic [LW-1:0]    w_rx_level;
  logic [2*DSZ-1:0] w_tx_data;
  logic [2*DSZ-1:0] w_rx_data;
  logic             w_tx_full;
  logic             w_tx_empty;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic             w_tx_push;
  logic             w_rx_pop;
  logic             w_overrun_inc;

  logic [1:0]       w_state_nxt;
  logic             w_tx_pop;
  logic             w_rx_push;
  logic             w_hold_load;
  logic [2*DSZ-1:0] w_hold_nxt;
  logic             w_underrun_inc;

  // Right word is fresh on the rising lrclk edge, so that is the frame boundary.
  assign w_tick        = i2s_lrclk & ~r_lrclk_q;
  assign w_tx_full     = (w_tx_level == LVL_FULL);
  assign w_tx_empty    = (w_tx_level == '0);
  assign w_rx_full     = (w_rx_level == LVL_FULL);
  assign w_rx_empty    = (w_rx_level == '0);
  assign w_tx_push     = tx_valid & ~reset & ~w_tx_full;
  assign w_rx_pop      = rx_ready & ~w_rx_empty;
  assign w_overrun_inc = w_rx_push & w_rx_full & ~w_rx_pop;

  // Sequencer: next state, FIFO strobes and the value loaded into the holds.
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_pop       = 1'b0;
    w_rx_push      = 1'b0;
    w_hold_load    = w_tick;
    w_hold_nxt     = '0;
    w_underrun_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_PRIME;
        else        w_state_nxt = ST_IDLE;
      end
      ST_PRIME: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick && (w_tx_level >= LVL_PREFILL)) begin
          w_state_nxt = ST_RUN;
          w_tx_pop    = 1'b1;
          w_hold_nxt  = w_tx_data;
        end else begin
          w_state_nxt = ST_PRIME;
        end
      end
      ST_RUN: begin
        if (w_tick) begin
          w_rx_push = 1'b1;
          if (!enable) begin
            w_state_nxt = ST_IDLE;
          end else if (!w_tx_empty) begin
            w_tx_pop   = 1'b1;
            w_hold_nxt = w_tx_data;
          end else begin
            w_underrun_inc = 1'b1;
            // In RUN the holds always carry the most recently popped frame.
            if (UNDERRUN_MODE == UNDERRUN_REPEAT) w_hold_nxt = {r_left_tx, r_right_tx};
            else                                  w_hold_nxt = '0;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, lrclk history and the TX holds seen by the master.
  always_ff @(posedge i2s_bclk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_lrclk_q  <= 1'b1;
      r_left_tx  <= '0;
      r_right_tx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lrclk_q <= i2s_lrclk;
      if (w_hold_load) {r_left_tx, r_right_tx} <= w_hold_nxt;
    end
  end

  // Saturating error counters; clear wins over a same-cycle increment.
  always_ff @(posedge i2s_bclk) begin
    if (reset || cnt_clear) begin
      r_underrun_cnt <= 8'd0;
      r_overrun_cnt  <= 8'd0;
    end else begin
      if (w_underrun_inc) r_underrun_cnt <= sat_inc8(r_underrun_cnt);
      if (w_overrun_inc)  r_overrun_cnt  <= sat_inc8(r_overrun_cnt);
    end
  end

  i2s_frame_scheduler_fifo #(.WIDTH(2*DSZ), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (i2s_bclk),
    .reset     (reset),
    .push      (w_tx_push),
    .push_data ({tx_left, tx_right}),
    .pop       (w_tx_pop),
    .pop_data  (w_tx_data),
    .level     (w_tx_level)
  );

  i2s_frame_scheduler_fifo #(.WIDTH(2*DSZ), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (i2s_bclk),
    .reset     (reset),
    .push      (w_rx_push),
    .push_data ({i2s_left_rx, i2s_right_rx}),
    .pop       (w_rx_pop),
    .pop_data  (w_rx_data),
    .level     (w_rx_level)
  );

  assign i2s_left_tx  = r_left_tx;
  assign i2s_right_tx = r_right_tx;
  assign tx_ready     = ~reset & ~w_tx_full;
  assign rx_valid     = ~reset & ~w_rx_empty;
  assign rx_left      = w_rx_data[2*DSZ-1:DSZ];
  assign rx_right     = w_rx_data[DSZ-1:0];
  assign frame_tick   = w_tick;
  assign state        = r_state;
  assign tx_level     = w_tx_level;
  assign underrun_cnt = r_underrun_cnt;
  assign overrun_cnt  = r_overrun_cnt;

endmodule
